// File: rtl/seq_det_ctrl_if.sv
// Pattern configuration handshake between the register interface and seq_det_ctrl.
// The master offers a pattern with cfg_valid; the controller accepts it when cfg_ready is high.
interface seq_det_ctrl_if #(
  parameter int PAT_W = 8
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;

  modport master (
    output cfg_valid,
    output cfg_pattern,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_pattern,
    output cfg_ready
  );

endinterface

// File: rtl/seq_det_ctrl.sv
// Sequencer for the seq_8 serial pattern detector in the CAN receive path.
// It loads a pattern MSB-first into the detector, then streams bus bits into it
// and counts qualified detections in a saturating counter.
// Optional feature macro: SEQ_DET_CTRL_IRQ_EN adds a sticky irq with irq_ack.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_ctrl_if.slave    cfg,
  input  logic             disarm,
  input  logic             rx_bit,
  input  logic             clr_cnt,
  output logic             det_load,
  output logic             det_din,
  input  logic             det_dout,
  output logic             armed,
  output logic             match_pulse,
`ifdef SEQ_DET_CTRL_IRQ_EN
  input  logic             irq_ack,
  output logic             irq,
`endif
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GRD_W = $clog2(PAT_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAT_W - 1);
  localparam logic [GRD_W-1:0] GUARD_MAX = GRD_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [PAT_W-1:0] shreg_r, shreg_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [GRD_W-1:0] guard_r, guard_s;
  logic             load_s, din_s;
  logic             hs_s, qual_s, ready_s;
  logic             load_r, din_r, armed_r, pulse_r;
  logic [CNT_W-1:0] cnt_r;

  // The controller can take a new pattern whenever it is not mid-load.
  assign ready_s       = (state_r == IDLE) || (state_r == ARMED);
  assign cfg.cfg_ready = ready_s;
  assign hs_s          = cfg.cfg_valid & ready_s;

  // A detection only counts once the detector window holds bus bits only.
  assign qual_s = (state_r == ARMED) && (guard_r == GUARD_MAX) && det_dout;

  // Next-state logic: disarm beats a same-cycle handshake; a reload drops guard progress.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    idx_s   = idx_r;
    guard_s = guard_r;
    case (state_r)
      IDLE: begin
        if (hs_s && !disarm) begin
          state_s = LOAD;
          shreg_s = cfg.cfg_pattern;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (disarm) begin
          state_s = IDLE;
        end else if (idx_r == LAST_IDX) begin
          state_s = ARMED;
          guard_s = '0;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          shreg_s = {shreg_r[PAT_W-2:0], 1'b0};
        end
      end
      ARMED: begin
        if (disarm) begin
          state_s = IDLE;
        end else if (hs_s) begin
          state_s = LOAD;
          shreg_s = cfg.cfg_pattern;
          idx_s   = '0;
          guard_s = '0;
        end else if (guard_r != GUARD_MAX) begin
          guard_s = guard_r + GRD_W'(1);
        end else begin
          guard_s = guard_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Detector drive for the coming cycle, derived from the next state so it can be registered.
  always_comb begin
    load_s = 1'b0;
    din_s  = 1'b0;
    case (state_s)
      LOAD: begin
        load_s = 1'b1;
        din_s  = shreg_s[PAT_W-1];
      end
      ARMED: begin
        load_s = 1'b0;
        din_s  = rx_bit;
      end
      default: begin
        load_s = 1'b0;
        din_s  = 1'b0;
      end
    endcase
  end

  // State, shift register, and registered detector/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= '0;
      idx_r   <= '0;
      guard_r <= '0;
      load_r  <= 1'b0;
      din_r   <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      idx_r   <= idx_s;
      guard_r <= guard_s;
      load_r  <= load_s;
      din_r   <= din_s;
      armed_r <= (state_s == ARMED);
    end
  end

  // Match pulse and saturating counter; clr_cnt overrides a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      pulse_r <= qual_s;
      if (clr_cnt) begin
        cnt_r <= '0;
      end else if (qual_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

`ifdef SEQ_DET_CTRL_IRQ_EN
  logic irq_r;

  // Sticky interrupt: a new match sets it even when acknowledged in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else if (qual_s) begin
      irq_r <= 1'b1;
    end else if (irq_ack) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign irq = irq_r;
`endif

  assign det_load    = load_r;
  assign det_din     = din_r;
  assign armed       = armed_r;
  assign match_pulse = pulse_r;
  assign match_cnt   = cnt_r;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl; the bench plays the role of the seq_8 detector.
module tb_seq_det_ctrl;

  logic       clk;
  logic       rst;
  logic       disarm;
  logic       rx_bit;
  logic       clr_cnt;
  logic       det_load;
  logic       det_din;
  logic       det_dout;
  logic       armed;
  logic       match_pulse;
  logic [7:0] match_cnt;
`ifdef SEQ_DET_CTRL_IRQ_EN
  logic       irq_ack;
  logic       irq;
`endif

  int tests_run;
  int tests_failed;

  seq_det_ctrl_if #(.PAT_W(8)) cfg_bus ();

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_bus),
    .disarm      (disarm),
    .rx_bit      (rx_bit),
    .clr_cnt     (clr_cnt),
    .det_load    (det_load),
    .det_din     (det_din),
    .det_dout    (det_dout),
    .armed       (armed),
    .match_pulse (match_pulse),
`ifdef SEQ_DET_CTRL_IRQ_EN
    .irq_ack     (irq_ack),
    .irq         (irq),
`endif
    .match_cnt   (match_cnt)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit reached");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    int exp_cnt;
    tests_run    = 0;
    tests_failed = 0;
    rst                 = 1'b1;
    cfg_bus.cfg_valid   = 1'b0;
    cfg_bus.cfg_pattern = 8'h00;
    disarm              = 1'b0;
    rx_bit              = 1'b0;
    clr_cnt             = 1'b0;
    det_dout            = 1'b0;
`ifdef SEQ_DET_CTRL_IRQ_EN
    irq_ack             = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_eq("rst_load",  32'(det_load),    32'd0);
    check_eq("rst_din",   32'(det_din),     32'd0);
    check_eq("rst_armed", 32'(armed),       32'd0);
    check_eq("rst_pulse", 32'(match_pulse), 32'd0);
    check_eq("rst_cnt",   32'(match_cnt),   32'd0);
    rst = 1'b0;
    step();

    // Load 1010_0110: handshake in cycle T.
    pat = 8'b1010_0110;
    cfg_bus.cfg_pattern = pat;
    cfg_bus.cfg_valid   = 1'b1;
    check_eq("idle_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    step();
    cfg_bus.cfg_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq("load_a6_load", 32'(det_load), 32'd1);
      check_eq("load_a6_din",  32'(det_din),  32'(pat[7-k]));
      check_eq("load_a6_armed", 32'(armed),   32'd0);
      if (k == 0) check_eq("load_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      step();
    end
    check_eq("armed_t9",    32'(armed),    32'd1);
    check_eq("armed_load",  32'(det_load), 32'd0);
    check_eq("armed_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_eq("armed_cnt0",  32'(match_cnt), 32'd0);

    // Detector fires during the first 8 ARMED cycles: suppressed by the guard.
    det_dout = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq("guard_pulse", 32'(match_pulse), 32'd0);
    end
    det_dout = 1'b0;
    step();
    check_eq("guard_cnt", 32'(match_cnt), 32'd0);
    det_dout = 1'b1;            // ARMED cycle 10
    step();
    det_dout = 1'b0;
    check_eq("first_pulse", 32'(match_pulse), 32'd1);
    check_eq("first_cnt",   32'(match_cnt),   32'd1);

    // Bus bit appears on det_din one cycle later.
    rx_bit = 1'b1;
    step();
    check_eq("stream_1", 32'(det_din), 32'd1);
    rx_bit = 1'b0;
    step();
    check_eq("stream_0", 32'(det_din), 32'd0);
    check_eq("stream_nopulse", 32'(match_pulse), 32'd0);

    // 260 matches from a held level: saturate at 255.
    det_dout = 1'b1;
    for (int j = 1; j <= 260; j++) begin
      step();
      exp_cnt = (1 + j > 255) ? 255 : 1 + j;
      if (j == 3 || j == 254 || j == 260) check_eq("sat_cnt", 32'(match_cnt), 32'(exp_cnt));
    end
    check_eq("sat_pulse", 32'(match_pulse), 32'd1);
    clr_cnt = 1'b1;
    step();
    check_eq("clr_win_cnt",   32'(match_cnt),   32'd0);
    check_eq("clr_win_pulse", 32'(match_pulse), 32'd1);
    clr_cnt  = 1'b0;
    det_dout = 1'b0;
    step();
    check_eq("after_clr_cnt",   32'(match_cnt),   32'd0);
    check_eq("after_clr_pulse", 32'(match_pulse), 32'd0);

    // Reload 8'hFF while ARMED.
    cfg_bus.cfg_pattern = 8'hFF;
    cfg_bus.cfg_valid   = 1'b1;
    step();
    cfg_bus.cfg_valid = 1'b0;
    check_eq("reload_armed0", 32'(armed), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check_eq("load_ff_load", 32'(det_load), 32'd1);
      check_eq("load_ff_din",  32'(det_din),  32'd1);
      step();
    end
    check_eq("reload_armed1", 32'(armed), 32'd1);
    det_dout = 1'b1;            // guard restarted: must stay quiet
    step();
    det_dout = 1'b0;
    check_eq("reload_guard", 32'(match_pulse), 32'd0);

    // Reload again and disarm in load cycle 3.
    cfg_bus.cfg_valid = 1'b1;
    step();
    cfg_bus.cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check_eq("lc3_load", 32'(det_load), 32'd1);
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    check_eq("disarm_load",  32'(det_load), 32'd0);
    check_eq("disarm_din",   32'(det_din),  32'd0);
    check_eq("disarm_armed", 32'(armed),    32'd0);
    check_eq("disarm_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    // Disarm together with a handshake: pattern dropped.
    cfg_bus.cfg_valid = 1'b1;
    disarm            = 1'b1;
    step();
    cfg_bus.cfg_valid = 1'b0;
    disarm            = 1'b0;
    check_eq("disarm_hs_load", 32'(det_load), 32'd0);

    // Asynchronous reset in load cycle 5 (din = pattern bit 2 = 1).
    cfg_bus.cfg_pattern = 8'b1010_0110;
    cfg_bus.cfg_valid   = 1'b1;
    step();
    cfg_bus.cfg_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_eq("lc5_din", 32'(det_din), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_load",  32'(det_load), 32'd0);
    check_eq("arst_din",   32'(det_din),  32'd0);
    check_eq("arst_armed", 32'(armed),    32'd0);
    check_eq("arst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_eq("arst_pulse", 32'(match_pulse), 32'd0);
    #1;
    rst = 1'b0;
    step();
    check_eq("arst_idle_load", 32'(det_load), 32'd0);

`ifdef SEQ_DET_CTRL_IRQ_EN
    check_eq("irq_rst", 32'(irq), 32'd0);
    cfg_bus.cfg_valid = 1'b1;
    step();
    cfg_bus.cfg_valid = 1'b0;
    repeat (16) step();         // 8 load cycles, then 8 guarded ARMED cycles
    det_dout = 1'b1;
    step();
    det_dout = 1'b0;
    check_eq("irq_set", 32'(irq), 32'd1);
    step();
    check_eq("irq_hold", 32'(irq), 32'd1);
    det_dout = 1'b1;
    irq_ack  = 1'b1;
    step();
    det_dout = 1'b0;
    check_eq("irq_set_wins", 32'(irq), 32'd1);
    step();
    irq_ack = 1'b0;
    check_eq("irq_ack", 32'(irq), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Controller that sequences the 8-bit serial sequence detector (`seq_8`) in the CAN controller receive path. It accepts a parallel target pattern over a valid/ready handshake and shifts it into the detector MSB-first with `load` asserted. It then arms the detector, streams received bus bits into it, and counts qualified detections. The block sits between the register interface (pattern/control) and the `seq_8` instance.

## Interface
- `PAT_W`, 8: pattern length in bits; must equal the detector's pattern length.
- `CNT_W`, 8: width of the match counter.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `cfg_valid`  input  1  new pattern offered.
- `cfg_ready`  output  1  controller can accept a pattern (IDLE or ARMED).
- `cfg_pattern`  input  PAT_W  pattern; captured on handshake.
- `disarm`  input  1  return to IDLE.
- `rx_bit`  input  1  received bus bit; one bit per clock.
- `clr_cnt`  input  1  synchronous clear of `match_cnt`.
- `det_load`  output  1  drives detector `load`.
- `det_din`  output  1  drives detector `din`.
- `det_dout`  input  1  detector match output.
- `armed`  output  1  state is ARMED.
- `match_pulse`  output  1  one-cycle pulse per qualified match.
- `match_cnt`  output  CNT_W  saturating match count.

## Operation
- States:
  - IDLE: `det_load`=0, `det_din`=0.
  - LOAD: shifts the pattern, PAT_W cycles.
  - ARMED: streams `rx_bit` into the detector.
- IDLE→LOAD on handshake (`cfg_valid & cfg_ready`). The pattern is latched into a shift register and the bit index is reset to 0.
- LOAD: `det_load`=1 and `det_din`=pattern[PAT_W-1-k] in load cycle k. After cycle PAT_W-1 the state becomes ARMED. `cfg_valid` is ignored (`cfg_ready`=0).
- ARMED: `det_load`=0 and `det_din` = `rx_bit` registered one cycle. A guard counter suppresses `det_dout` for the first PAT_W ARMED cycles, because the detector window is not yet filled with bus bits.
- Handshake in ARMED restarts LOAD with the new pattern. Any in-flight guard state is discarded.
- `disarm` in LOAD or ARMED moves the state to IDLE next cycle and aborts a partial load.
- If `disarm` and a handshake occur in the same cycle, `disarm` wins and the pattern is dropped.
- Qualified match: ARMED, guard expired, and `det_dout`=1. Each such cycle counts once, so a level held N cycles counts N matches.
- `match_cnt` saturates at 2^CNT_W-1 and does not wrap.
- If `clr_cnt` and a match occur in the same cycle, `clr_cnt` has priority: the count becomes 0. The pulse is still emitted.
- `match_cnt` is retained across IDLE/LOAD/ARMED transitions. Only `rst` or `clr_cnt` clears it.

## Timing
- Reset values:
  - state IDLE; `cfg_ready`=1.
  - `det_load`=0, `det_din`=0.
  - `armed`=0, `match_pulse`=0, `match_cnt`=0.
- `cfg_ready` is combinational from state.
- LOAD sequence, with the handshake in cycle T:
  - `det_load`=1 in cycles T+1..T+PAT_W.
  - `det_din` = pattern bit PAT_W-1-k in cycle T+1+k.
  - `armed`=1 from T+PAT_W+1.
- Bus streaming: `rx_bit` sampled in cycle n appears on `det_din` in cycle n+1.
- Match latency: a qualified `det_dout` in cycle n raises `match_pulse` and updates `match_cnt` in cycle n+1.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); the latched pattern is lost.

## Configuration
- `SEQ_DET_CTRL_IRQ_EN` defined:
  - Adds input `irq_ack` and output `irq`.
  - `irq` is set in cycle n+1 by a qualified match in cycle n.
  - `irq` stays set until `irq_ack` is sampled high; set wins over a simultaneous ack. Reset value 0.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

## Test plan
- Reset, then handshake pattern 8'b1010_0110 at T → `det_load`=1 for T+1..T+8, `det_din` = 1,0,1,0,0,1,1,0; `armed`=1 at T+9; `match_cnt`=0.
- While ARMED, model detector asserts `det_dout` in the first 8 ARMED cycles → no pulse, count stays 0. `det_dout` asserted in ARMED cycle 10 → `match_pulse` in cycle 11, `match_cnt`=1.
- Force 260 qualified matches with CNT_W=8 → `match_cnt` saturates at 255. `clr_cnt` coinciding with a match → `match_cnt`=0, `match_pulse`=1.
- Handshake pattern 8'hFF in ARMED → `armed`=0 next cycle, 8 load cycles of `din`=1. Assert `disarm` at load cycle 3 → IDLE next cycle, `det_load`=0.
- Assert `rst` during LOAD cycle 5 → all outputs 0 and `cfg_ready`=1 without waiting for a clock edge.
- With `SEQ_DET_CTRL_IRQ_EN`: qualified match → `irq`=1 and held. `irq_ack` in the same cycle as a new match → `irq` remains 1. A later ack alone → `irq`=0.
